// File: rtl/execute.sv
// RISC-V EX stage: operand forwarding, ALU, beq resolution and the EX/MEM register.
// Branch outputs are combinational. E inputs reach the M outputs 1 cycle later. There is no backpressure and no stall; the register captures on every edge.
module execute (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwriteE,
  input  logic        memwriteE,
  input  logic        branchE,
  input  logic        alusrcE,
  input  logic        resultsrcE,
  input  logic [2:0]  alucontrolE,
  input  logic [31:0] r1E,
  input  logic [31:0] r2E,
  input  logic [4:0]  RdE,
  input  logic [31:0] imm_addrE,
  input  logic [31:0] pcE,
  input  logic [31:0] pc4E,
  input  logic [31:0] ResultW,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        regwriteM,
  output logic        memwriteM,
  output logic        resultsrcM,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [4:0]  RdM,
  output logic [31:0] pc4M
);

  typedef struct packed {
    logic        regwrite;
    logic        memwrite;
    logic        resultsrc;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
    logic [31:0] pc4;
  } exmem_t;

  exmem_t      exmem_d, exmem_q;
  logic [31:0] src_a, src_b, write_data, alu_result;
  logic        zero;

  // Code 11 is never issued by the hazard unit; it falls back to the register-file value.
  always_comb begin
    src_a = r1E;
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = exmem_q.alu_result;
      default: src_a = r1E;
    endcase
  end

  always_comb begin
    write_data = r2E;
    case (ForwardBE)
      2'b01:   write_data = ResultW;
      2'b10:   write_data = exmem_q.alu_result;
      default: write_data = r2E;
    endcase
  end

  assign src_b = alusrcE ? imm_addrE : write_data;

  always_comb begin
    alu_result = 32'h0;
    case (alucontrolE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = ($signed(src_a) < $signed(src_b)) ? 32'h1 : 32'h0;
      default: alu_result = 32'h0;
    endcase
  end

  assign zero = (alu_result == 32'h0);

  // The branch outputs are gated by reset so that fetch sees no redirect while the pipe is held.
  assign PCSrcE    = rst & branchE & zero;
  assign PCTargetE = rst ? (pcE + imm_addrE) : 32'h0;

  always_comb begin
    exmem_d            = '0;
    exmem_d.regwrite   = regwriteE;
    exmem_d.memwrite   = memwriteE;
    exmem_d.resultsrc  = resultsrcE;
    exmem_d.alu_result = alu_result;
    exmem_d.write_data = write_data;
    exmem_d.rd         = RdE;
    exmem_d.pc4        = pc4E;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) exmem_q <= '0;
    else      exmem_q <= exmem_d;
  end

  assign regwriteM  = exmem_q.regwrite;
  assign memwriteM  = exmem_q.memwrite;
  assign resultsrcM = exmem_q.resultsrc;
  assign ALUResultM = exmem_q.alu_result;
  assign WriteDataM = exmem_q.write_data;
  assign RdM        = exmem_q.rd;
  assign pc4M       = exmem_q.pc4;

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage with hand-computed expected values.
module tb_execute;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        regwriteE = 1'b0, memwriteE = 1'b0, branchE = 1'b0, alusrcE = 1'b0, resultsrcE = 1'b0;
  logic [2:0]  alucontrolE = 3'b000;
  logic [31:0] r1E = '0, r2E = '0, imm_addrE = '0, pcE = '0, pc4E = '0, ResultW = '0;
  logic [4:0]  RdE = '0;
  logic [1:0]  ForwardAE = 2'b00, ForwardBE = 2'b00;
  logic        PCSrcE, regwriteM, memwriteM, resultsrcM;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, pc4M;
  logic [4:0]  RdM;

  int compared   = 0;
  int mismatched = 0;

  execute dut (
    .clk(clk), .rst(rst),
    .regwriteE(regwriteE), .memwriteE(memwriteE), .branchE(branchE),
    .alusrcE(alusrcE), .resultsrcE(resultsrcE), .alucontrolE(alucontrolE),
    .r1E(r1E), .r2E(r2E), .RdE(RdE), .imm_addrE(imm_addrE),
    .pcE(pcE), .pc4E(pc4E), .ResultW(ResultW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .regwriteM(regwriteM), .memwriteM(memwriteM), .resultsrcM(resultsrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .pc4M(pc4M)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".PCSrcE"},     {31'b0, PCSrcE},     32'h0);
    check({tag, ".PCTargetE"},  PCTargetE,           32'h0);
    check({tag, ".regwriteM"},  {31'b0, regwriteM},  32'h0);
    check({tag, ".memwriteM"},  {31'b0, memwriteM},  32'h0);
    check({tag, ".resultsrcM"}, {31'b0, resultsrcM}, 32'h0);
    check({tag, ".ALUResultM"}, ALUResultM,          32'h0);
    check({tag, ".WriteDataM"}, WriteDataM,          32'h0);
    check({tag, ".RdM"},        {27'b0, RdM},        32'h0);
    check({tag, ".pc4M"},       pc4M,                32'h0);
  endtask

  initial begin
    // Reset held with every input nonzero; a taken branch is presented too.
    regwriteE = 1; memwriteE = 1; resultsrcE = 1; branchE = 1; alusrcE = 0;
    alucontrolE = 3'b001; r1E = 32'h55; r2E = 32'h55; RdE = 5'd9;
    imm_addrE = 32'h4; pcE = 32'h100; pc4E = 32'h104; ResultW = 32'h77;
    ForwardAE = 2'b00; ForwardBE = 2'b00;
    tick(); tick(); tick();
    check_all_zero("rst_hold");

    // Release, then add 5 + 7.
    rst = 1;
    regwriteE = 0; memwriteE = 0; resultsrcE = 0; branchE = 0;
    alucontrolE = 3'b000; r1E = 32'd5; r2E = 32'd7; RdE = 5'd0; pc4E = 32'h0;
    tick();
    check("first_add", ALUResultM, 32'd12);

    // ALU sweep
    r1E = 32'hFFFF_FFF0; r2E = 32'h0000_0010;
    alucontrolE = 3'b000; tick(); check("alu_add", ALUResultM, 32'h0);
    alucontrolE = 3'b001; tick(); check("alu_sub", ALUResultM, 32'hFFFF_FFE0);
    alucontrolE = 3'b010; tick(); check("alu_and", ALUResultM, 32'h10);
    alucontrolE = 3'b011; tick(); check("alu_or",  ALUResultM, 32'hFFFF_FFF0);
    alucontrolE = 3'b101; tick(); check("alu_slt", ALUResultM, 32'h1);
    alucontrolE = 3'b111; tick(); check("alu_111", ALUResultM, 32'h0);
    alucontrolE = 3'b101; r1E = 32'h10; r2E = 32'hFFFF_FFF0;
    tick(); check("alu_slt_neg", ALUResultM, 32'h0);
    alucontrolE = 3'b100; r1E = 32'h3; r2E = 32'h1;
    tick(); check("alu_100", ALUResultM, 32'h0);

    // Branch taken / not taken, combinational
    branchE = 1; alucontrolE = 3'b001; r1E = 32'd9; r2E = 32'd9;
    pcE = 32'h100; imm_addrE = 32'hFFFF_FFF8;
    #1;
    check("br_taken",  {31'b0, PCSrcE}, 32'h1);
    check("br_target", PCTargetE, 32'hF8);
    r2E = 32'd8;
    #1;
    check("br_not_taken", {31'b0, PCSrcE}, 32'h0);
    check("br_target2",   PCTargetE, 32'hF8);
    tick();
    branchE = 0;

    // Back-to-back forwarding
    alucontrolE = 3'b000; r1E = 32'd15; r2E = 32'd5; alusrcE = 0;
    tick(); check("fwd_producer", ALUResultM, 32'd20);
    ForwardAE = 2'b10; r1E = 32'd0; imm_addrE = 32'd3; alusrcE = 1;
    tick(); check("fwd_exmem", ALUResultM, 32'd23);
    ForwardAE = 2'b00; ForwardBE = 2'b01; ResultW = 32'd44; memwriteE = 1; r2E = 32'd1;
    tick();
    check("fwd_wb_store", WriteDataM, 32'd44);
    check("fwd_memwrite", {31'b0, memwriteM}, 32'h1);
    ForwardAE = 2'b11; ForwardBE = 2'b11; r1E = 32'd7; r2E = 32'd2; memwriteE = 0;
    tick();
    check("fwd11_a", ALUResultM, 32'd10);
    check("fwd11_b", WriteDataM, 32'd2);
    ForwardAE = 2'b00; ForwardBE = 2'b00;

    // Pass-through
    regwriteE = 1; resultsrcE = 1; RdE = 5'd17; pc4E = 32'h204;
    tick();
    check("pt_regwrite",  {31'b0, regwriteM},  32'h1);
    check("pt_resultsrc", {31'b0, resultsrcM}, 32'h1);
    check("pt_rd",        {27'b0, RdM},        32'd17);
    check("pt_pc4",       pc4M,                32'h204);

    // Mid-stream asynchronous reset with a taken branch on the inputs
    branchE = 1; alucontrolE = 3'b001; alusrcE = 0; r1E = 32'd4; r2E = 32'd4;
    pcE = 32'h40; imm_addrE = 32'h10;
    #2;
    rst = 0;
    #1;
    check_all_zero("async_rst");
    #2;
    rst = 1;
    #1;
    check("post_rst_hold_alu", ALUResultM, 32'h0);
    check("post_rst_hold_rd",  {27'b0, RdM}, 32'h0);
    tick();
    check("post_rst_capture_rd",  {27'b0, RdM}, 32'd17);
    check("post_rst_capture_pc4", pc4M, 32'h204);
    check("post_rst_br",          {31'b0, PCSrcE}, 32'h1);
    check("post_rst_target",      PCTargetE, 32'h50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
